// File: rtl/uart_tx_fifo_if.sv
// Word handshake between a system-side producer and the UART transmitter FIFO.
//   P_DATA     : word to transmit (DATA_WIDTH bits)
//   DATA_valid : producer requests a push of P_DATA
//   DATA_ready : FIFO can accept a word this cycle (not full)
// The master modport is the producer; the slave modport is the transmitter.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_valid;
    logic                  DATA_ready;

    modport master (
        output P_DATA,
        output DATA_valid,
        input  DATA_ready
    );

    modport slave (
        input  P_DATA,
        input  DATA_valid,
        output DATA_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO.
// Words pushed through the word_bus handshake are queued and sent as
// start / DATA_WIDTH data bits (LSB first) / optional parity / 1 or 2 stop bits.
// Frame configuration is captured when a word leaves the FIFO, so changes to the
// config inputs only affect frames that have not started yet.
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   word_bus   : P_DATA / DATA_valid in, DATA_ready out (DATA_ready = FIFO not full)
//   PAR_EN     : append a parity bit
//   PAR_TYP    : 0 even parity, 1 odd parity
//   STOP2      : 0 one stop bit, 1 two stop bits
//   PRESCALE   : clocks per bit, 0 treated as 1
//   TX_OUT     : serial line, idle high
//   busy       : a frame is on the line
//   fifo_count : number of queued words
//   overrun    : one-cycle pulse after a push was attempted while full
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESC_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    uart_tx_fifo_if.slave                 word_bus,
    input  logic                          PAR_EN,
    input  logic                          PAR_TYP,
    input  logic                          STOP2,
    input  logic [PRESC_W-1:0]            PRESCALE,
    output logic                          TX_OUT,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic [CW-1:0]         count_next;
    logic                  ready_reg;
    logic                  overrun_reg;

    // Frame state
    logic [2:0]            state_reg;
    logic                  tx_reg;
    logic                  busy_reg;
    logic [PRESC_W-1:0]    cnt_reg;
    logic [PRESC_W-1:0]    presc_m1_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [IW-1:0]         idx_reg;
    logic                  par_en_reg;
    logic                  par_bit_reg;
    logic                  stop2_reg;
    logic                  stop_second_reg;

    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  frame_done;
    logic [DATA_WIDTH-1:0] head;
    logic [PRESC_W-1:0]    load_cnt;

    assign push       = word_bus.DATA_valid & ready_reg;
    assign fifo_empty = (count_reg == '0);
    assign bit_end    = (cnt_reg == '0);
    // Last clock of the final stop bit
    assign frame_done = (state_reg == ST_STOP) && bit_end && (!stop2_reg || stop_second_reg);
    // A new frame is loaded either from idle or seamlessly at the end of the previous one
    assign pop        = !fifo_empty && ((state_reg == ST_IDLE) || frame_done);
    assign head       = mem[rd_ptr_reg];
    // Down-counter reload: bit lasts max(PRESCALE,1) clocks
    assign load_cnt   = (PRESCALE == '0) ? '0 : PRESCALE - 1'b1;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= word_bus.P_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ready_reg   <= 1'b1;
            overrun_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg   <= count_next;
            // Registered so DATA_ready reflects the count after this edge
            ready_reg   <= (count_next != CW'(FIFO_DEPTH));
            overrun_reg <= word_bus.DATA_valid & ~ready_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            tx_reg          <= 1'b1;
            busy_reg        <= 1'b0;
            cnt_reg         <= '0;
            presc_m1_reg    <= '0;
            shift_reg       <= '0;
            idx_reg         <= '0;
            par_en_reg      <= 1'b0;
            par_bit_reg     <= 1'b0;
            stop2_reg       <= 1'b0;
            stop_second_reg <= 1'b0;
        end else if (pop) begin
            // Capture word and configuration; the start bit begins on this edge
            state_reg       <= ST_START;
            tx_reg          <= 1'b0;
            busy_reg        <= 1'b1;
            cnt_reg         <= load_cnt;
            presc_m1_reg    <= load_cnt;
            shift_reg       <= head;
            idx_reg         <= '0;
            par_en_reg      <= PAR_EN;
            par_bit_reg     <= (^head) ^ PAR_TYP;
            stop2_reg       <= STOP2;
            stop_second_reg <= 1'b0;
        end else if (state_reg != ST_IDLE) begin
            if (!bit_end) begin
                cnt_reg <= cnt_reg - 1'b1;
            end else begin
                cnt_reg <= presc_m1_reg;
                case (state_reg)
                    ST_START: begin
                        state_reg <= ST_DATA;
                        idx_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                    end
                    ST_DATA: begin
                        if (idx_reg == IW'(DATA_WIDTH - 1)) begin
                            if (par_en_reg) begin
                                state_reg <= ST_PARITY;
                                tx_reg    <= par_bit_reg;
                            end else begin
                                state_reg       <= ST_STOP;
                                tx_reg          <= 1'b1;
                                stop_second_reg <= 1'b0;
                            end
                        end else begin
                            idx_reg   <= idx_reg + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            tx_reg    <= shift_reg[1];
                        end
                    end
                    ST_PARITY: begin
                        state_reg       <= ST_STOP;
                        tx_reg          <= 1'b1;
                        stop_second_reg <= 1'b0;
                    end
                    ST_STOP: begin
                        if (stop2_reg && !stop_second_reg) begin
                            stop_second_reg <= 1'b1;
                        end else begin
                            // FIFO empty here, otherwise pop would have reloaded a frame
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                            tx_reg    <= 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        tx_reg    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign word_bus.DATA_ready = ready_reg;
    assign TX_OUT              = tx_reg;
    assign busy                = busy_reg;
    assign fifo_count          = count_reg;
    assign overrun             = overrun_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected frames are queued when words are pushed,
// and a per-instance line monitor decodes TX_OUT and compares bit by bit.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    typedef struct {
        logic [15:0] bits;   // bits[0] is transmitted first (start bit)
        int          nbits;
        int          presc;
    } frame_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        par_en, par_typ, stop2;
    logic [15:0] prescale;
    logic        cfg1_par_en, cfg1_par_typ, cfg1_stop2;
    logic [15:0] cfg1_prescale;

    logic       tx0, busy0, ovr0;
    logic [2:0] cnt0;
    logic       tx1, busy1, ovr1;
    logic [2:0] cnt1;

    uart_tx_fifo_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_fifo_if #(.DATA_WIDTH(5)) bus1 ();

    uart_tx_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .word_bus(bus0),
        .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2), .PRESCALE(prescale),
        .TX_OUT(tx0), .busy(busy0), .fifo_count(cnt0), .overrun(ovr0)
    );

    uart_tx_fifo #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .PRESC_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .word_bus(bus1),
        .PAR_EN(cfg1_par_en), .PAR_TYP(cfg1_par_typ), .STOP2(cfg1_stop2), .PRESCALE(cfg1_prescale),
        .TX_OUT(tx1), .busy(busy1), .fifo_count(cnt1), .overrun(ovr1)
    );

    int checks = 0;
    int errors = 0;

    frame_t q0[$];
    frame_t q1[$];
    bit     mon_active[2];
    int     frames_seen[2];
    int     busy_cyc[2];
    int     busy_falls[2];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic frame_t mkf(input logic [8:0] data, input int dw, input bit pe,
                                   input bit pb, input bit s2, input int presc);
        frame_t f;
        int n;
        n = 0;
        f.bits = '0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < dw; i++) begin
            f.bits[n] = data[i]; n++;
        end
        if (pe) begin
            f.bits[n] = pb; n++;
        end
        f.bits[n] = 1'b1; n++;
        if (s2) begin
            f.bits[n] = 1'b1; n++;
        end
        f.nbits = n;
        f.presc = presc;
        return f;
    endfunction

    function automatic logic tx_of(input int u);
        return (u == 0) ? tx0 : tx1;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction

    function automatic int qsize(input int u);
        return (u == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int u, input frame_t f);
        if (u == 0) q0.push_back(f);
        else        q1.push_back(f);
    endtask

    task automatic run_monitor(input int u);
        frame_t f;
        logic   gotb;
        int     fidx;
        bit     aborted;
        fidx = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_of(u) == 1'b0) begin
                if (qsize(u) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_u%0d: got start bit, expected idle line", u);
                    for (int k = 0; k < 2000 && busy_of(u) && rst_n; k++) @(negedge clk);
                end else begin
                    if (u == 0) f = q0.pop_front();
                    else        f = q1.pop_front();
                    mon_active[u] = 1'b1;
                    aborted = 1'b0;
                    for (int b = 0; b < f.nbits && !aborted; b++) begin
                        gotb = f.bits[b];
                        for (int s = 0; s < f.presc && !aborted; s++) begin
                            if (b != 0 || s != 0) @(negedge clk);
                            if (!rst_n) aborted = 1'b1;
                            else if (tx_of(u) !== f.bits[b]) gotb = tx_of(u);
                        end
                        if (!aborted)
                            chk($sformatf("u%0d_frame%0d_bit%0d", u, fidx, b), 32'(gotb), 32'(f.bits[b]));
                    end
                    if (aborted) begin
                        if (u == 0) q0.delete();
                        else        q1.delete();
                    end else begin
                        fidx++;
                    end
                    frames_seen[u]++;
                    mon_active[u] = 1'b0;
                end
            end
        end
    endtask

    initial run_monitor(0);
    initial run_monitor(1);

    initial begin
        bit prev0, prev1;
        prev0 = 1'b0;
        prev1 = 1'b0;
        forever begin
            @(negedge clk);
            if (busy0) busy_cyc[0]++;
            if (busy1) busy_cyc[1]++;
            if (prev0 && !busy0) busy_falls[0]++;
            if (prev1 && !busy1) busy_falls[1]++;
            prev0 = busy0;
            prev1 = busy1;
        end
    end

    task automatic push0(input logic [7:0] d);
        @(negedge clk);
        bus0.P_DATA     = d;
        bus0.DATA_valid = 1'b1;
        @(negedge clk);
        bus0.DATA_valid = 1'b0;
    endtask

    task automatic push1(input logic [4:0] d);
        @(negedge clk);
        bus1.P_DATA     = d;
        bus1.DATA_valid = 1'b1;
        @(negedge clk);
        bus1.DATA_valid = 1'b0;
    endtask

    task automatic wait_idle(input int u, input int maxc);
        int k;
        k = 0;
        while (k < maxc && (qsize(u) != 0 || mon_active[u] || busy_of(u))) begin
            @(negedge clk);
            k++;
        end
        if (k >= maxc) begin
            checks++;
            errors++;
            $display("FAIL timeout_u%0d: still busy after %0d cycles, expected idle", u, maxc);
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    int b0, f0, fs;
    logic [7:0] words [6];

    initial begin
        rst_n           = 1'b0;
        bus0.P_DATA     = '0;
        bus0.DATA_valid = 1'b0;
        bus1.P_DATA     = '0;
        bus1.DATA_valid = 1'b0;
        par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; prescale = 16'd4;
        cfg1_par_en = 1'b0; cfg1_par_typ = 1'b0; cfg1_stop2 = 1'b0; cfg1_prescale = 16'd0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;

        repeat (3) @(negedge clk);
        chk("reset_tx",     32'(tx0), 32'd1);
        chk("reset_busy",   32'(busy0), 32'd0);
        chk("reset_ready",  32'(bus0.DATA_ready), 32'd1);
        chk("reset_count",  32'(cnt0), 32'd0);
        chk("reset_ovr",    32'(ovr0), 32'd0);
        chk("reset_tx_u1",  32'(tx1), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic 8N1, 4 clocks per bit
        b0 = busy_cyc[0]; f0 = busy_falls[0];
        qpush(0, mkf(9'h0A5, 8, 0, 0, 0, 4));
        push0(8'hA5);
        chk("t1_busy_before_pop", 32'(busy0), 32'd0);
        @(negedge clk);
        chk("t1_latency_busy", 32'(busy0), 32'd1);
        chk("t1_latency_tx",   32'(tx0), 32'd0);
        wait_idle(0, 200);
        chk("t1_busy_cycles", 32'(busy_cyc[0] - b0), 32'd40);
        chk("t1_busy_falls",  32'(busy_falls[0] - f0), 32'd1);

        // Parity even / odd, then two stop bits, 1 clock per bit
        prescale = 16'd1; par_en = 1'b1; par_typ = 1'b0;
        b0 = busy_cyc[0];
        qpush(0, mkf(9'h0A5, 8, 1, 0, 0, 1));
        push0(8'hA5);
        wait_idle(0, 100);
        chk("t2_even_cycles", 32'(busy_cyc[0] - b0), 32'd11);
        par_typ = 1'b1;
        b0 = busy_cyc[0];
        qpush(0, mkf(9'h0A5, 8, 1, 1, 0, 1));
        push0(8'hA5);
        wait_idle(0, 100);
        chk("t2_odd_cycles", 32'(busy_cyc[0] - b0), 32'd11);
        par_typ = 1'b0; stop2 = 1'b1;
        b0 = busy_cyc[0];
        qpush(0, mkf(9'h0A5, 8, 1, 0, 1, 1));
        push0(8'hA5);
        wait_idle(0, 100);
        chk("t2_stop2_cycles", 32'(busy_cyc[0] - b0), 32'd12);

        // Back-to-back with overrun on the sixth word
        par_en = 1'b0; stop2 = 1'b0; prescale = 16'd4;
        b0 = busy_cyc[0]; f0 = busy_falls[0];
        for (int i = 0; i < 5; i++) qpush(0, mkf({1'b0, words[i]}, 8, 0, 0, 0, 4));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) chk("t3_ready_full", 32'(bus0.DATA_ready), 32'd0);
            bus0.P_DATA     = words[i];
            bus0.DATA_valid = 1'b1;
        end
        @(negedge clk);
        bus0.DATA_valid = 1'b0;
        chk("t3_overrun_pulse", 32'(ovr0), 32'd1);
        chk("t3_count_full",    32'(cnt0), 32'd4);
        @(negedge clk);
        chk("t3_overrun_clear", 32'(ovr0), 32'd0);
        wait_idle(0, 400);
        chk("t3_busy_cycles", 32'(busy_cyc[0] - b0), 32'd200);
        chk("t3_busy_falls",  32'(busy_falls[0] - f0), 32'd1);
        chk("t3_ready_after", 32'(bus0.DATA_ready), 32'd1);

        // Reset during data bit 3 with a word still queued
        qpush(0, mkf(9'h0F0, 8, 0, 0, 0, 4));
        qpush(0, mkf(9'h00F, 8, 0, 0, 0, 4));
        push0(8'hF0);
        push0(8'h0F);
        for (int k = 0; k < 50 && !busy0; k++) @(negedge clk);
        repeat (17) @(negedge clk);
        chk("t4_prereset_tx",    32'(tx0), 32'd0);
        chk("t4_prereset_count", 32'(cnt0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_reset_tx",    32'(tx0), 32'd1);
        chk("t4_reset_busy",  32'(busy0), 32'd0);
        chk("t4_reset_count", 32'(cnt0), 32'd0);
        chk("t4_reset_ready", 32'(bus0.DATA_ready), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        fs = frames_seen[0]; b0 = busy_cyc[0];
        repeat (60) @(negedge clk);
        chk("t4_no_frames_after", 32'(frames_seen[0] - fs), 32'd0);
        chk("t4_no_busy_after",   32'(busy_cyc[0] - b0), 32'd0);
        chk("t4_line_idle",       32'(tx0), 32'd1);

        // Config change mid-frame only affects the next frame
        prescale = 16'd4; par_en = 1'b0; par_typ = 1'b0;
        b0 = busy_cyc[0]; f0 = busy_falls[0];
        qpush(0, mkf(9'h03C, 8, 0, 0, 0, 4));
        qpush(0, mkf(9'h081, 8, 1, 0, 0, 2));
        push0(8'h3C);
        push0(8'h81);
        repeat (8) @(negedge clk);
        prescale = 16'd2; par_en = 1'b1;
        wait_idle(0, 300);
        chk("t5_busy_cycles", 32'(busy_cyc[0] - b0), 32'd62);
        chk("t5_busy_falls",  32'(busy_falls[0] - f0), 32'd1);

        // DATA_WIDTH=5, PRESCALE=0
        b0 = busy_cyc[1];
        qpush(1, mkf(9'h013, 5, 0, 0, 0, 1));
        push1(5'h13);
        @(negedge clk);
        chk("t6_latency_tx", 32'(tx1), 32'd0);
        wait_idle(1, 100);
        chk("t6_busy_cycles", 32'(busy_cyc[1] - b0), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
